// File: rtl/bayer_raw2rgb.sv
// rtl/bayer_raw2rgb.sv - GRBG Bayer quad to 24-bit RGB converter with one-line buffer
// Each 2x2 quad emits one RGB pixel; outputs are aligned two clocks after the completing sample.
module bayer_raw2rgb #(
  parameter int LINE_WIDTH = 1280,
  parameter int CNT_W      = 12
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic [11:0] iDATA,
  input  logic        iDVAL,
  input  logic        iFVAL,
  output logic [23:0] oRGB,
  output logic        oDVAL,
  output logic        oFVAL,
  output logic        oARMED
);

  localparam int AW = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;

  logic [11:0]      line_mem [LINE_WIDTH];

  logic [CNT_W-1:0] col_cnt_q, col_cnt_d;
  logic [CNT_W-1:0] row_cnt_q, row_cnt_d;
  logic             dval_q;
  logic             armed_q;

  logic [11:0]      cur_q, prv_q, up_q, upprv_q;
  logic             hit1_q, hit2_q;
  logic [23:0]      rgb2_q;
  logic             fval1_q, fval2_q;

  logic             in_range;
  logic             hit_d;
  logic [AW-1:0]    addr;
  logic [12:0]      gsum;

  assign in_range = (col_cnt_q < CNT_W'(LINE_WIDTH));
  assign addr     = col_cnt_q[AW-1:0];
  assign hit_d    = iDVAL & iFVAL & armed_q & row_cnt_q[0] & col_cnt_q[0] & in_range;
  assign gsum     = {1'b0, upprv_q} + {1'b0, cur_q};

  // Frame-low clears take priority over the end-of-line advance.
  always_comb begin
    col_cnt_d = col_cnt_q;
    row_cnt_d = row_cnt_q;
    if (!iFVAL) begin
      col_cnt_d = '0;
      row_cnt_d = '0;
    end else if (iDVAL) begin
      col_cnt_d = (col_cnt_q == '1) ? col_cnt_q : col_cnt_q + 1'b1;
    end else if (dval_q) begin
      col_cnt_d = '0;
      row_cnt_d = (row_cnt_q == '1) ? row_cnt_q : row_cnt_q + 1'b1;
    end
  end

  // Line RAM: the read in the reset block sees the pre-write contents.
  always_ff @(posedge iCLK) begin
    if (iDVAL && in_range) begin
      line_mem[addr] <= iDATA;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      col_cnt_q <= '0;
      row_cnt_q <= '0;
      dval_q    <= 1'b0;
      armed_q   <= 1'b0;
      cur_q     <= '0;
      prv_q     <= '0;
      up_q      <= '0;
      upprv_q   <= '0;
      hit1_q    <= 1'b0;
      hit2_q    <= 1'b0;
      rgb2_q    <= '0;
      fval1_q   <= 1'b0;
      fval2_q   <= 1'b0;
      oRGB      <= '0;
      oDVAL     <= 1'b0;
      oFVAL     <= 1'b0;
    end else begin
      col_cnt_q <= col_cnt_d;
      row_cnt_q <= row_cnt_d;
      dval_q    <= iDVAL;
      armed_q   <= armed_q | ~iFVAL;
      if (iDVAL) begin
        cur_q   <= iDATA;
        prv_q   <= cur_q;
        up_q    <= in_range ? line_mem[addr] : 12'd0;
        upprv_q <= up_q;
      end
      hit1_q <= hit_d;
      hit2_q <= hit1_q;
      if (hit1_q) begin
        rgb2_q <= {up_q[11:4], gsum[12:5], prv_q[11:4]};
      end
      oDVAL <= hit2_q;
      if (hit2_q) begin
        oRGB <= rgb2_q;
      end
      fval1_q <= iFVAL;
      fval2_q <= fval1_q;
      oFVAL   <= fval2_q;
    end
  end

  assign oARMED = armed_q;

endmodule
